// File: rtl/bb_regbank_pkg.sv
// bb_regbank_pkg: shared opcode and FSM state types for the register-bank arbiter
package bb_regbank_pkg;
  typedef enum logic [1:0] {OP_WRITE, OP_SET, OP_CLEAR, OP_READ} op_e;
  typedef enum logic {ST_IDLE, ST_FLUSH} state_e;
endpackage

// File: rtl/bb_regbank_arb_if.sv
// bb_regbank_arb_if: requester-side request/response bundle
interface bb_regbank_arb_if #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8,
  parameter int DW    = 8
);
  localparam int AW = $clog2(DEPTH);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [2*NREQ-1:0]  req_op;
  logic [AW*NREQ-1:0] req_addr;
  logic [DW*NREQ-1:0] req_data;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  modport master (output req_valid, req_op, req_addr, req_data, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, req_op, req_addr, req_data, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/bb_en_flop.sv
// bb_en_flop: enable-loaded register cell with async reset and async set
module bb_en_flop #(
  parameter int DW = 8,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_n,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  // reset wins over set; otherwise load d when enabled
  always_ff @(posedge clk or negedge rst_n or negedge set_n)
    if (!rst_n) q <= RST_VAL;
    else if (!set_n) q <= '1;
    else if (en) q <= d;
endmodule

// File: rtl/bb_rr_arb.sv
// bb_rr_arb: round-robin picker, first valid requester at or after ptr
module bb_rr_arb #(
  parameter int NREQ = 4,
  localparam int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx
);
  logic found;
  int j;
  // scan upward from ptr with wrap, keeping the first hit
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    j = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        grant[j] = 1'b1;
        idx = PW'(j);
      end
    end
  end
endmodule

// File: rtl/bb_regbank_arb.sv
// bb_regbank_arb: round-robin sequencer sharing a register bank, with flush FSM
module bb_regbank_arb
  import bb_regbank_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8,
  parameter int DW    = 8,
  parameter logic [DW-1:0] RST_VAL = '0,
  parameter logic [DW-1:0] SET_VAL = DW'(1)
) (
  input  logic                clk,
  input  logic                rst_n,
  bb_regbank_arb_if.slave     bus,
  input  logic                flush_req,
  output logic                busy,
  output logic                flush_done,
  output logic [DEPTH*DW-1:0] bank_q
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(NREQ);
  state_e state, state_nx;
  logic [AW-1:0] fcnt, addr;
  logic [PW-1:0] ptr, idx;
  logic [NREQ-1:0] grant;
  logic acc;
  op_e op;
  logic [DW-1:0] wdata, d;
  logic [DEPTH-1:0] en;
  bb_rr_arb #(.NREQ(NREQ)) u_arb (.req_valid(bus.req_valid), .ptr, .grant, .idx);
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nx;
  // FSM next state: enter flush on request, leave after the last entry
  always_comb
    state_nx = state == ST_IDLE ? (flush_req ? ST_FLUSH : ST_IDLE)
             : (fcnt == AW'(DEPTH - 1) ? ST_IDLE : ST_FLUSH);
  // FSM outputs: flush has priority over grants, and reset forces grants off
  always_comb begin
    busy = state == ST_FLUSH;
    flush_done = busy && fcnt == AW'(DEPTH - 1);
    bus.req_ready = (rst_n && !busy && !flush_req) ? grant : '0;
  end
  // decode the granted request into a single bank write
  always_comb begin
    acc = |bus.req_ready;
    op = op_e'(bus.req_op[int'(idx)*2 +: 2]);
    addr = bus.req_addr[int'(idx)*AW +: AW];
    wdata = bus.req_data[int'(idx)*DW +: DW];
    d = busy ? RST_VAL : op == OP_WRITE ? wdata : op == OP_SET ? SET_VAL : RST_VAL;
    for (int e = 0; e < DEPTH; e++)
      en[e] = busy ? fcnt == AW'(e) : acc && op != OP_READ && addr == AW'(e);
  end
  // pointer, flush counter and registered read response
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      fcnt <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data <= '0;
    end else begin
      fcnt <= busy ? fcnt + 1'b1 : '0;
      if (acc) ptr <= idx == PW'(NREQ - 1) ? '0 : idx + 1'b1;
      bus.rsp_valid <= (acc && op == OP_READ) ? bus.req_ready : '0;
      if (acc && op == OP_READ) bus.rsp_data <= bank_q[int'(addr)*DW +: DW];
    end
  for (genvar i = 0; i < DEPTH; i++) begin : g_bank
    bb_en_flop #(.DW(DW), .RST_VAL(RST_VAL)) u_cell (
      .clk, .rst_n, .set_n(1'b1), .en(en[i]), .d, .q(bank_q[i*DW +: DW])
    );
  end
endmodule

// File: tb/tb_bb_regbank_arb.sv
// tb_bb_regbank_arb: directed self-checking bench for bb_regbank_arb
module tb_bb_regbank_arb;
  logic clk, rst_n, flush_req, busy, flush_done;
  logic [63:0] bank_q;
  int tests = 0, fails = 0;
  bb_regbank_arb_if #(.NREQ(4), .DEPTH(8), .DW(8)) bus ();
  bb_regbank_arb #(.NREQ(4), .DEPTH(8), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush_req(flush_req),
    .busy(busy), .flush_done(flush_done), .bank_q(bank_q)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    flush_req = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_op = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    #3;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_bank", bank_q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", flush_done, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    step;
    step;
    rst_n = 1'b1;
    bus.req_addr = {3'd3, 3'd2, 3'd1, 3'd0};
    bus.req_data = 32'h13121110;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rot_ready", bus.req_ready, 64'(1 << (k % 4)));
      step;
    end
    bus.req_valid = '0;
    chk("rot_bank", bank_q[31:0], 32'h13121110);
    bus.req_valid = 4'b0100;
    bus.req_op = 8'b00_01_00_00;
    bus.req_addr = 12'd5 << 6;
    #1;
    chk("set_ready", bus.req_ready, 4'b0100);
    step;
    chk("set_entry5", bank_q[47:40], 8'h01);
    bus.req_op = 8'b00_10_00_00;
    #1;
    chk("clr_ready", bus.req_ready, 4'b0100);
    step;
    chk("clr_entry5", bank_q[47:40], 8'h00);
    bus.req_op = 8'b00_11_00_00;
    #1;
    chk("rd_ready", bus.req_ready, 4'b0100);
    step;
    bus.req_valid = '0;
    chk("rd_rsp_valid", bus.rsp_valid, 4'b0100);
    chk("rd_rsp_data", bus.rsp_data, 8'h00);
    chk("rd_bank", bank_q, 64'h0000_0000_1312_1110);
    step;
    chk("rd_rsp_clear", bus.rsp_valid, 0);
    bus.req_valid = 4'b1000;
    bus.req_op = '0;
    bus.req_addr = 12'd3 << 9;
    bus.req_data = 32'hAA00_0000;
    #1;
    chk("aa_ready", bus.req_ready, 4'b1000);
    step;
    chk("aa_entry3", bank_q[31:24], 8'hAA);
    bus.req_valid = 4'b0010;
    bus.req_op = 8'b00_00_11_00;
    bus.req_addr = 12'd3 << 3;
    #1;
    chk("pre_rd_ready", bus.req_ready, 4'b0010);
    step;
    bus.req_valid = 4'b0001;
    bus.req_op = '0;
    bus.req_addr = 12'd3;
    bus.req_data = 32'h0000_0055;
    #1;
    chk("pre_rsp_valid", bus.rsp_valid, 4'b0010);
    chk("pre_rsp_data", bus.rsp_data, 8'hAA);
    chk("pre_wr_ready", bus.req_ready, 4'b0001);
    step;
    bus.req_valid = '0;
    chk("pre_entry3", bank_q[31:24], 8'h55);
    chk("pre_rsp_clear", bus.rsp_valid, 0);
    bus.req_valid = 4'hF;
    bus.req_addr = {3'd3, 3'd2, 3'd1, 3'd0};
    bus.req_data = 32'h7777_7777;
    flush_req = 1'b1;
    #1;
    chk("fl_prio_ready", bus.req_ready, 0);
    step;
    flush_req = 1'b0;
    chk("fl_no_accept", bank_q, 64'h0000_0000_5512_1110);
    for (int c = 0; c < 8; c++) begin
      chk("fl_busy", busy, 1);
      chk("fl_done", flush_done, 64'(c == 7));
      chk("fl_ready", bus.req_ready, 0);
      if (c == 3) flush_req = 1'b1;
      if (c == 4) flush_req = 1'b0;
      step;
    end
    chk("fl_busy_end", busy, 0);
    chk("fl_done_end", flush_done, 0);
    chk("fl_bank", bank_q, 0);
    chk("fl_resume_ready", bus.req_ready, 4'b0010);
    step;
    bus.req_valid = '0;
    chk("fl_resume_bank", bank_q, 64'h0000_0000_0000_7700);
    bus.req_valid = 4'b0011;
    bus.req_op = '0;
    bus.req_addr = (12'd7 << 3) | 12'd6;
    bus.req_data = 32'h0000_9966;
    #1;
    chk("drop_ready", bus.req_ready, 4'b0001);
    step;
    bus.req_valid = '0;
    chk("drop_bank", bank_q, 64'h0066_0000_0000_7700);
    step;
    chk("drop_bank_hold", bank_q, 64'h0066_0000_0000_7700);
    chk("drop_no_rsp", bus.rsp_valid, 0);
    bus.req_valid = 4'b0010;
    bus.req_op = 8'b00_00_11_00;
    bus.req_addr = 12'd6 << 3;
    #1;
    chk("mr_rd_ready", bus.req_ready, 4'b0010);
    step;
    bus.req_valid = '0;
    flush_req = 1'b1;
    chk("mr_rsp_valid", bus.rsp_valid, 4'b0010);
    chk("mr_rsp_data", bus.rsp_data, 8'h66);
    step;
    flush_req = 1'b0;
    chk("mr_busy", busy, 1);
    step;
    step;
    bus.req_valid = 4'hF;
    bus.req_op = '0;
    rst_n = 1'b0;
    #1;
    chk("mr_rst_busy", busy, 0);
    chk("mr_rst_bank", bank_q, 0);
    chk("mr_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mr_rst_rsp_data", bus.rsp_data, 0);
    chk("mr_rst_done", flush_done, 0);
    chk("mr_rst_ready", bus.req_ready, 0);
    step;
    step;
    rst_n = 1'b1;
    #1;
    chk("mr_post_ready", bus.req_ready, 4'b0001);
    step;
    bus.req_valid = '0;
    chk("mr_post_rsp", bus.rsp_valid, 0);
    chk("mr_post_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
